// File: rtl/ifetch_stage.sv
// rtl/ifetch_stage.sv - instruction fetch stage: PC accept, imem req/ack, IF/ID holding register.
// Optional predecode outputs enabled by `define IFETCH_PREDECODE_EN.
module ifetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h00400020,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic        pc_valid,
  output logic        pc_ready,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic        fetch_err,
  output logic        id_is_beq,
  output logic [15:0] id_imm16
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        req_d, valid_d, err_d, drop_q, drop_d;
  logic [31:0] addr_d, instr_d, pc_d;
  logic [15:0] cnt_q, cnt_d;
  logic        accept;

  assign pc_ready = (state_q == IDLE) | ((state_q == HOLD) & id_ready & ~flush);
  assign accept   = pc_valid & pc_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      id_valid  <= 1'b0;
      id_instr  <= 32'h0;
      id_pc     <= RESET_PC;
      fetch_err <= 1'b0;
      cnt_q     <= 16'd0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      imem_req  <= req_d;
      imem_addr <= addr_d;
      id_valid  <= valid_d;
      id_instr  <= instr_d;
      id_pc     <= pc_d;
      fetch_err <= err_d;
      cnt_q     <= cnt_d;
      drop_q    <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = imem_req;
    addr_d  = imem_addr;
    valid_d = id_valid;
    instr_d = id_instr;
    pc_d    = id_pc;
    err_d   = fetch_err;
    cnt_d   = 16'd0;
    drop_d  = drop_q;

    case (state_q)
      REQ: begin
        cnt_d = cnt_q + 16'd1;
        if (imem_ack) begin
          req_d = 1'b0;
          cnt_d = 16'd0;
          if (drop_q | flush) begin
            state_d = IDLE;
            drop_d  = 1'b0;
          end else begin
            state_d = HOLD;
            instr_d = imem_rdata;
            err_d   = 1'b0;
            valid_d = 1'b1;
          end
        end else begin
          // The bus request is never withdrawn early; a flush only marks the data as dead.
          if (flush) drop_d = 1'b1;
          if (cnt_q == TO_LAST) begin
            req_d = 1'b0;
            cnt_d = 16'd0;
            if (drop_q | flush) begin
              state_d = IDLE;
              drop_d  = 1'b0;
            end else begin
              state_d = HOLD;
              instr_d = 32'h0;
              err_d   = 1'b1;
              valid_d = 1'b1;
            end
          end
        end
      end
      HOLD: begin
        if (flush | id_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      default: ;
    endcase

    // Accept covers both IDLE and the back-to-back HOLD handoff.
    if (accept) begin
      pc_d = pc_in;
      if (pc_in[1:0] == 2'b00) begin
        state_d = REQ;
        req_d   = 1'b1;
        addr_d  = pc_in;
        valid_d = 1'b0;
        cnt_d   = 16'd0;
      end else begin
        state_d = HOLD;
        instr_d = 32'h0;
        err_d   = 1'b1;
        valid_d = 1'b1;
      end
    end
  end

`ifdef IFETCH_PREDECODE_EN
  assign id_is_beq = id_valid & ~fetch_err & (id_instr[31:26] == 6'b000100);
  assign id_imm16  = id_instr[15:0];
`else
  assign id_is_beq = 1'b0;
  assign id_imm16  = 16'h0;
`endif

endmodule

// File: tb/tb_ifetch_stage.sv
// tb/tb_ifetch_stage.sv - vector table, corner sequences and random run against a transaction model.
module tb_ifetch_stage;

  localparam logic [31:0] RPC = 32'h00400020;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst, pc_valid, flush, imem_ack, id_ready;
  logic [31:0] pc_in, imem_rdata;
  logic        pc_ready, imem_req, id_valid, fetch_err, id_is_beq;
  logic [31:0] imem_addr, id_instr, id_pc;
  logic [15:0] id_imm16;

  ifetch_stage #(.RESET_PC(RPC), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .pc_valid(pc_valid), .pc_ready(pc_ready),
    .flush(flush), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
    .id_pc(id_pc), .fetch_err(fetch_err), .id_is_beq(id_is_beq), .id_imm16(id_imm16)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Transaction-level reference: an outstanding fetch and/or a held instruction.
  bit          m_fetching, m_holding, m_drop, m_err;
  int          m_wait;
  logic [31:0] m_addr, m_pc, m_instr;
  logic        s_rdy, e_rdy;

  function automatic void model_step();
    if (rst) begin
      m_fetching = 0; m_holding = 0; m_drop = 0; m_err = 0; m_wait = 0;
      m_addr = RPC; m_pc = RPC; m_instr = 32'h0;
    end else if (m_fetching) begin
      m_wait++;
      if (imem_ack) begin
        m_fetching = 0;
        if (m_drop || flush) m_drop = 0;
        else begin m_holding = 1; m_instr = imem_rdata; m_err = 0; end
      end else begin
        if (flush) m_drop = 1;
        if (m_wait == TO) begin
          m_fetching = 0;
          if (m_drop) m_drop = 0;
          else begin m_holding = 1; m_instr = 32'h0; m_err = 1; end
        end
      end
    end else begin
      bit take;
      take = pc_valid && (!m_holding || (id_ready && !flush));
      if (m_holding && (flush || id_ready)) m_holding = 0;
      if (take) begin
        m_pc = pc_in;
        if (pc_in[1:0] == 2'b00) begin
          m_fetching = 1; m_addr = pc_in; m_wait = 0;
        end else begin
          m_holding = 1; m_instr = 32'h0; m_err = 1;
        end
      end
    end
  endfunction

  task automatic apply(input logic r, input logic pv, input logic [31:0] pc, input logic fl,
                       input logic ack, input logic [31:0] rd, input logic idr);
    rst = r; pc_valid = pv; pc_in = pc; flush = fl; imem_ack = ack; imem_rdata = rd; id_ready = idr;
    #1;
    s_rdy = pc_ready;
    e_rdy = !m_fetching && (!m_holding || (id_ready && !flush));
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rdy(input string name, input logic exp);
    n_vec++;
    if (s_rdy !== exp) begin
      n_bad++;
      $display("FAIL %s pc_ready: got %b want %b", name, s_rdy, exp);
    end
  endtask

  task automatic check_out(input string name, input logic x_req, input logic [31:0] x_addr,
                           input logic x_v, input logic [31:0] x_instr, input logic [31:0] x_pc,
                           input logic x_err);
    logic [115:0] act, exp;
    logic         x_beq;
    logic [15:0]  x_imm;
`ifdef IFETCH_PREDECODE_EN
    x_beq = x_v & ~x_err & (x_instr[31:26] == 6'b000100);
    x_imm = x_v ? x_instr[15:0] : 16'h0;
`else
    x_beq = 1'b0;
    x_imm = 16'h0;
`endif
    exp = {x_req, x_addr, x_v, x_v ? x_instr : 32'h0, x_pc, x_v & x_err, x_beq, x_imm};
    act = {imem_req, imem_addr, id_valid, x_v ? id_instr : 32'h0, id_pc, x_v & fetch_err,
           id_is_beq, x_v ? id_imm16 : 16'h0};
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s {req,addr,valid,instr,pc,err,beq,imm16}: got %h want %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic r, pv; logic [31:0] pc; logic fl, ack; logic [31:0] rd; logic idr;
    logic x_rdy, x_req; logic [31:0] x_addr; logic x_v; logic [31:0] x_instr, x_pc; logic x_err;
  } vec_t;

  function automatic vec_t mk(logic r, logic pv, logic [31:0] pc, logic fl, logic ack,
                              logic [31:0] rd, logic idr, logic x_rdy, logic x_req,
                              logic [31:0] x_addr, logic x_v, logic [31:0] x_instr,
                              logic [31:0] x_pc, logic x_err);
    vec_t v;
    v.r = r; v.pv = pv; v.pc = pc; v.fl = fl; v.ack = ack; v.rd = rd; v.idr = idr;
    v.x_rdy = x_rdy; v.x_req = x_req; v.x_addr = x_addr; v.x_v = x_v;
    v.x_instr = x_instr; v.x_pc = x_pc; v.x_err = x_err;
    return v;
  endfunction

  vec_t tbl[20];

  initial begin
    int n_high;
    //           r  pv pc            fl ack rdata         idr rdy req addr          v  instr         pc            err
    tbl[0]  = mk(1, 0, 32'h0,        0, 0, 32'h0,        0,  1,  0,  RPC,          0, 32'h0,        RPC,          0);
    tbl[1]  = mk(0, 1, 32'h00400020, 0, 0, 32'h0,        0,  1,  1,  32'h00400020, 0, 32'h0,        32'h00400020, 0);
    tbl[2]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        0,  0,  1,  32'h00400020, 0, 32'h0,        32'h00400020, 0);
    tbl[3]  = mk(0, 0, 32'h0,        0, 1, 32'h20080005, 0,  0,  0,  32'h00400020, 1, 32'h20080005, 32'h00400020, 0);
    tbl[4]  = mk(0, 1, 32'h00400024, 0, 0, 32'h0,        0,  0,  0,  32'h00400020, 1, 32'h20080005, 32'h00400020, 0);
    tbl[5]  = mk(0, 1, 32'h00400024, 0, 1, 32'h12345678, 0,  0,  0,  32'h00400020, 1, 32'h20080005, 32'h00400020, 0);
    tbl[6]  = mk(0, 1, 32'h00400024, 0, 0, 32'h0,        0,  0,  0,  32'h00400020, 1, 32'h20080005, 32'h00400020, 0);
    tbl[7]  = mk(0, 1, 32'h00400024, 0, 0, 32'h0,        1,  1,  1,  32'h00400024, 0, 32'h0,        32'h00400024, 0);
    tbl[8]  = mk(0, 0, 32'h0,        0, 1, 32'h8c090000, 0,  0,  0,  32'h00400024, 1, 32'h8c090000, 32'h00400024, 0);
    tbl[9]  = mk(0, 1, 32'h00400022, 0, 0, 32'h0,        1,  1,  0,  32'h00400024, 1, 32'h0,        32'h00400022, 1);
    tbl[10] = mk(0, 0, 32'h0,        0, 0, 32'h0,        1,  1,  0,  32'h00400024, 0, 32'h0,        32'h00400022, 0);
    tbl[11] = mk(0, 1, 32'h00400028, 0, 0, 32'h0,        0,  1,  1,  32'h00400028, 0, 32'h0,        32'h00400028, 0);
    tbl[12] = mk(0, 0, 32'h0,        1, 0, 32'h0,        0,  0,  1,  32'h00400028, 0, 32'h0,        32'h00400028, 0);
    tbl[13] = mk(0, 0, 32'h0,        0, 0, 32'h0,        0,  0,  1,  32'h00400028, 0, 32'h0,        32'h00400028, 0);
    tbl[14] = mk(0, 0, 32'h0,        0, 0, 32'h0,        0,  0,  1,  32'h00400028, 0, 32'h0,        32'h00400028, 0);
    tbl[15] = mk(0, 0, 32'h0,        0, 1, 32'hdeadbeef, 0,  0,  0,  32'h00400028, 0, 32'h0,        32'h00400028, 0);
    tbl[16] = mk(0, 1, 32'h0040002c, 1, 0, 32'h0,        0,  1,  1,  32'h0040002c, 0, 32'h0,        32'h0040002c, 0);
    tbl[17] = mk(0, 0, 32'h0,        0, 1, 32'h11220033, 0,  0,  0,  32'h0040002c, 1, 32'h11220033, 32'h0040002c, 0);
    tbl[18] = mk(0, 1, 32'h00400030, 1, 0, 32'h0,        1,  0,  0,  32'h0040002c, 0, 32'h0,        32'h0040002c, 0);
    tbl[19] = mk(0, 0, 32'h0,        0, 0, 32'h0,        0,  1,  0,  32'h0040002c, 0, 32'h0,        32'h0040002c, 0);

    apply(1, 0, 0, 0, 0, 0, 0);
    apply(1, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 20; i++) begin
      apply(tbl[i].r, tbl[i].pv, tbl[i].pc, tbl[i].fl, tbl[i].ack, tbl[i].rd, tbl[i].idr);
      check_rdy($sformatf("tbl%0d", i), tbl[i].x_rdy);
      check_out($sformatf("tbl%0d", i), tbl[i].x_req, tbl[i].x_addr, tbl[i].x_v,
                tbl[i].x_instr, tbl[i].x_pc, tbl[i].x_err);
    end

    // Silent memory: request must stay up exactly TIMEOUT cycles.
    apply(0, 1, 32'h00400040, 0, 0, 0, 0);
    n_high = imem_req ? 1 : 0;
    for (int i = 0; i < 10; i++) begin
      apply(0, 0, 0, 0, 0, 0, 0);
      if (imem_req) n_high++;
      else break;
    end
    n_vec++;
    if (n_high != TO) begin
      n_bad++;
      $display("FAIL timeout_len req cycles: got %0d want %0d", n_high, TO);
    end
    check_out("timeout_err", 0, 32'h00400040, 1, 32'h0, 32'h00400040, 1);
    apply(0, 0, 0, 0, 0, 0, 1);
    check_out("timeout_consume", 0, 32'h00400040, 0, 32'h0, 32'h00400040, 0);

    // Timeout after a flush drops silently.
    apply(0, 1, 32'h00400044, 0, 0, 0, 0);
    apply(0, 0, 0, 1, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0, 0);
    check_out("flush_to_pre", 1, 32'h00400044, 0, 32'h0, 32'h00400044, 0);
    apply(0, 0, 0, 0, 0, 0, 0);
    check_out("flush_to_idle", 0, 32'h00400044, 0, 32'h0, 32'h00400044, 0);

    // Reset mid-request, then a late ack.
    apply(0, 1, 32'h00400048, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0, 0);
    apply(1, 0, 0, 0, 1, 32'hcafef00d, 0);
    check_out("rst_midreq", 0, RPC, 0, 32'h0, RPC, 0);
    apply(0, 0, 0, 0, 1, 32'hcafef00d, 0);
    check_rdy("late_ack_rdy", 1'b1);
    check_out("late_ack", 0, RPC, 0, 32'h0, RPC, 0);

    // Random traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      logic [31:0] pc;
      pc = $urandom;
      if ($urandom_range(0, 99) < 85) pc[1:0] = 2'b00;
      apply($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1, pc,
            $urandom_range(0, 9) == 0, $urandom_range(0, 99) < 30, $urandom,
            $urandom_range(0, 1) == 1);
      check_rdy($sformatf("rnd%0d", i), e_rdy);
      check_out($sformatf("rnd%0d", i), m_fetching, m_addr, m_holding, m_instr, m_pc, m_err);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
